// File: rtl/dual_word_data_mem.sv
// Dual-word data memory: single-port word array with a request/latency FSM.
// A request is captured on a falling edge, waits LATENCY edges, then performs
// either one word access (narrow) or two consecutive word accesses (wide).
// Wide accesses at the last address are refused with an error pulse rather
// than wrapping to address 0.
module dual_word_data_mem #(
  parameter int WORD_LENGTH   = 16,
  parameter int ADDRESS_SPACE = 12,
  parameter int LATENCY       = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       rw,
  input  logic                       wide,
  input  logic [ADDRESS_SPACE-1:0]   addr,
  input  logic [2*WORD_LENGTH-1:0]   wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2*WORD_LENGTH-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDRESS_SPACE;
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t                      state_r;
  logic [2:0]                  cnt_r;
  logic                        rw_r;
  logic                        wide_r;
  logic [ADDRESS_SPACE-1:0]    addr_r;
  logic [2*WORD_LENGTH-1:0]    wdata_r;
  logic                        busy_r;
  logic                        done_r;
  logic                        err_r;
  logic [2*WORD_LENGTH-1:0]    rdata_r;

  logic [WORD_LENGTH-1:0]      mem_r [DEPTH];

  logic                        last_addr_s;
  logic                        mem_we_s;
  logic [ADDRESS_SPACE-1:0]    mem_waddr_s;
  logic [WORD_LENGTH-1:0]      mem_wdata_s;

  // A wide access starting at the top word would need to wrap; flag it.
  assign last_addr_s = (addr_r == {ADDRESS_SPACE{1'b1}});

  // Decode the single array write port from the FSM state.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_r;
    mem_wdata_s = wdata_r[WORD_LENGTH-1:0];
    case (state_r)
      S_WAIT: begin
        if ((cnt_r == 3'd0) && !rw_r && !(wide_r && last_addr_s)) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = wide_r ? wdata_r[2*WORD_LENGTH-1:WORD_LENGTH]
                               : wdata_r[WORD_LENGTH-1:0];
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      S_SECOND: begin
        if (!rw_r) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = addr_r + ADDRESS_SPACE'(1);
          mem_wdata_s = wdata_r[WORD_LENGTH-1:0];
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        mem_we_s    = 1'b0;
      end
    endcase
  end

  // Word array: cleared on reset, otherwise written by the FSM's write port.
  always_ff @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Request FSM: accept, count down latency, perform first/second access.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 3'd0;
      rw_r    <= 1'b0;
      wide_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req) begin
            rw_r    <= rw;
            wide_r  <= wide;
            addr_r  <= addr;
            wdata_r <= wdata;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end else if (wide_r && last_addr_s) begin
            // Refuse the wrapping wide access; rdata is left untouched.
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (!wide_r) begin
            if (rw_r) begin
              rdata_r <= {{WORD_LENGTH{1'b0}}, mem_r[addr_r]};
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            if (rw_r) begin
              rdata_r[2*WORD_LENGTH-1:WORD_LENGTH] <= mem_r[addr_r];
            end
            state_r <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (rw_r) begin
            rdata_r[WORD_LENGTH-1:0] <= mem_r[addr_r + ADDRESS_SPACE'(1)];
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_dual_word_data_mem.sv
// Directed bench for dual_word_data_mem: instance a uses LATENCY=2, instance b
// uses LATENCY=1. Inputs change and outputs are sampled on rising edges, away
// from the falling edge the design uses.
module tb_dual_word_data_mem;

  logic        clk;
  logic        reset;
  logic        req_a, rw_a, wide_a;
  logic [11:0] addr_a;
  logic [31:0] wdata_a;
  logic        busy_a, done_a, err_a;
  logic [31:0] rdata_a;
  logic        req_b, rw_b, wide_b;
  logic [11:0] addr_b;
  logic [31:0] wdata_b;
  logic        busy_b, done_b, err_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_errors = 0;

  dual_word_data_mem #(.WORD_LENGTH(16), .ADDRESS_SPACE(12), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .rw(rw_a), .wide(wide_a),
    .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a),
    .err(err_a), .rdata(rdata_a)
  );

  dual_word_data_mem #(.WORD_LENGTH(16), .ADDRESS_SPACE(12), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .rw(rw_b), .wide(wide_b),
    .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b),
    .err(err_b), .rdata(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance a (sel=0) or b (sel=1) and wait for done.
  // lat is the number of falling edges from accept to done (20 = timed out).
  task automatic run_req(input bit sel, input bit rw, input bit wide,
                         input logic [11:0] addr, input logic [31:0] wd,
                         output int lat, output bit e);
    if (sel) begin
      req_b = 1'b1; rw_b = rw; wide_b = wide; addr_b = addr; wdata_b = wd;
    end else begin
      req_a = 1'b1; rw_a = rw; wide_a = wide; addr_a = addr; wdata_a = wd;
    end
    @(posedge clk);
    if (sel) req_b = 1'b0;
    else     req_a = 1'b0;
    lat = 0;
    while (!(sel ? done_b : done_a) && lat < 20) begin
      @(posedge clk);
      lat++;
    end
    e = sel ? err_b : err_a;
  endtask

  int lat;
  bit e;
  int n;
  bit saw_done;

  initial begin
    reset = 1'b0;
    req_a = 1'b0; rw_a = 1'b0; wide_a = 1'b0; addr_a = 12'h000; wdata_a = 32'h0;
    req_b = 1'b0; rw_b = 1'b0; wide_b = 1'b0; addr_b = 12'h000; wdata_b = 32'h0;
    repeat (3) @(posedge clk);
    chk_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    chk_eq("rst_done", {31'd0, done_a}, 32'd0);
    chk_eq("rst_err", {31'd0, err_a}, 32'd0);
    chk_eq("rst_rdata", rdata_a, 32'h0);
    chk_eq("rst_busy_b", {31'd0, busy_b}, 32'd0);
    reset = 1'b1;

    // Narrow write with cycle-by-cycle handshake checks.
    req_a = 1'b1; rw_a = 1'b0; wide_a = 1'b0; addr_a = 12'h010; wdata_a = 32'h0000BEEF;
    @(posedge clk);
    chk_eq("nw_busy_e0", {31'd0, busy_a}, 32'd1);
    req_a = 1'b0;
    @(posedge clk);
    chk_eq("nw_busy_e1", {31'd0, busy_a}, 32'd1);
    chk_eq("nw_done_e1", {31'd0, done_a}, 32'd0);
    @(posedge clk);
    chk_eq("nw_done_e2", {31'd0, done_a}, 32'd1);
    chk_eq("nw_busy_e2", {31'd0, busy_a}, 32'd0);
    chk_eq("nw_err_e2", {31'd0, err_a}, 32'd0);
    @(posedge clk);
    chk_eq("done_pulse", {31'd0, done_a}, 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, lat, e);
    chk_eq("nr_lat", 32'(lat), 32'd2);
    chk_eq("nr_data", rdata_a, 32'h0000BEEF);

    // Wide write/read pair and narrow read of the second word.
    run_req(1'b0, 1'b0, 1'b1, 12'h020, 32'h12345678, lat, e);
    chk_eq("ww_lat", 32'(lat), 32'd3);
    chk_eq("ww_keeps_rdata", rdata_a, 32'h0000BEEF);
    run_req(1'b0, 1'b1, 1'b1, 12'h020, 32'h0, lat, e);
    chk_eq("wr_lat", 32'(lat), 32'd3);
    chk_eq("wr_data", rdata_a, 32'h12345678);
    chk_eq("wr_err", {31'd0, e}, 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 12'h021, 32'h0, lat, e);
    chk_eq("nr021_data", rdata_a, 32'h00005678);

    // Wide access at the top address is refused.
    run_req(1'b0, 1'b0, 1'b0, 12'hFFF, 32'h0000AAAA, lat, e);
    run_req(1'b0, 1'b0, 1'b0, 12'h000, 32'h00005555, lat, e);
    run_req(1'b0, 1'b1, 1'b1, 12'hFFF, 32'h0, lat, e);
    chk_eq("edge_rd_lat", 32'(lat), 32'd2);
    chk_eq("edge_rd_err", {31'd0, e}, 32'd1);
    chk_eq("edge_rd_hold", rdata_a, 32'h00005678);
    @(posedge clk);
    chk_eq("err_pulse", {31'd0, err_a}, 32'd0);
    run_req(1'b0, 1'b0, 1'b1, 12'hFFF, 32'hDEADDEAD, lat, e);
    chk_eq("edge_wr_err", {31'd0, e}, 32'd1);
    run_req(1'b0, 1'b1, 1'b0, 12'hFFF, 32'h0, lat, e);
    chk_eq("mem_fff", rdata_a, 32'h0000AAAA);
    run_req(1'b0, 1'b1, 1'b0, 12'h000, 32'h0, lat, e);
    chk_eq("mem_000", rdata_a, 32'h00005555);

    // Inputs changing while busy are ignored; a held req is taken after done.
    req_a = 1'b1; rw_a = 1'b0; wide_a = 1'b0; addr_a = 12'h030; wdata_a = 32'h00001111;
    @(posedge clk);
    chk_eq("hold_busy", {31'd0, busy_a}, 32'd1);
    rw_a = 1'b1; addr_a = 12'h055; wdata_a = 32'h00002222;
    @(posedge clk);
    @(posedge clk);
    chk_eq("hold_done", {31'd0, done_a}, 32'd1);
    @(posedge clk);
    chk_eq("held_accept", {31'd0, busy_a}, 32'd1);
    chk_eq("held_done_low", {31'd0, done_a}, 32'd0);
    req_a = 1'b0;
    n = 0;
    while (!done_a && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk_eq("held_lat", 32'(n), 32'd2);
    chk_eq("mem_055_untouched", rdata_a, 32'h0);
    run_req(1'b0, 1'b1, 1'b0, 12'h030, 32'h0, lat, e);
    chk_eq("mem_030", rdata_a, 32'h00001111);

    // Reset during an in-flight wide write drops it without a done pulse.
    req_a = 1'b1; rw_a = 1'b0; wide_a = 1'b1; addr_a = 12'h040; wdata_a = 32'hCAFEF00D;
    @(posedge clk);
    chk_eq("rst_mid_busy", {31'd0, busy_a}, 32'd1);
    req_a = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    chk_eq("rst_mid_busy0", {31'd0, busy_a}, 32'd0);
    chk_eq("rst_mid_done0", {31'd0, done_a}, 32'd0);
    chk_eq("rst_mid_err0", {31'd0, err_a}, 32'd0);
    chk_eq("rst_mid_rdata0", rdata_a, 32'h0);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge clk);
      if (done_a) saw_done = 1'b1;
    end
    chk_eq("rst_no_done", {31'd0, saw_done}, 32'd0);
    run_req(1'b0, 1'b1, 1'b1, 12'h040, 32'h0, lat, e);
    chk_eq("rst_mem_040", rdata_a, 32'h0);
    run_req(1'b0, 1'b1, 1'b1, 12'h020, 32'h0, lat, e);
    chk_eq("rst_mem_020", rdata_a, 32'h0);
    run_req(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, lat, e);
    chk_eq("rst_mem_010", rdata_a, 32'h0);

    // LATENCY=1 instance: one-edge latency and back-to-back accepts.
    run_req(1'b1, 1'b0, 1'b0, 12'h007, 32'h0000ABCD, lat, e);
    chk_eq("b_wr_lat", 32'(lat), 32'd1);
    run_req(1'b1, 1'b0, 1'b0, 12'h008, 32'h00001234, lat, e);
    req_b = 1'b1; rw_b = 1'b1; wide_b = 1'b0; addr_b = 12'h007; wdata_b = 32'h0;
    @(posedge clk);
    chk_eq("b_busy_e0", {31'd0, busy_b}, 32'd1);
    chk_eq("b_done_e0", {31'd0, done_b}, 32'd0);
    wide_b = 1'b1;
    @(posedge clk);
    chk_eq("b_done_e1", {31'd0, done_b}, 32'd1);
    chk_eq("b_nr_data", rdata_b, 32'h0000ABCD);
    @(posedge clk);
    chk_eq("b2b_accept", {31'd0, busy_b}, 32'd1);
    chk_eq("b2b_done_low", {31'd0, done_b}, 32'd0);
    req_b = 1'b0;
    n = 0;
    while (!done_b && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk_eq("b2b_lat", 32'(n), 32'd2);
    chk_eq("b2b_data", rdata_b, 32'hABCD1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_word_data_mem.md
DUAL_WORD_DATA_MEM -- requirements
Module: dual_word_data_mem

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDRESS_SPACE, default 12, giving the address width, for 2^ADDRESS_SPACE words.
REQ-003 The block SHALL have parameter LATENCY, default 1, legal range 1..8, giving the falling edges from request accept to first array access.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on the falling edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port req, input, 1 bit: request strobe.
REQ-007 The block SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 The block SHALL have port wide, input, 1 bit: 1 = two-word access, 0 = one-word access.
REQ-009 The block SHALL have port addr, input, ADDRESS_SPACE bits: word address.
REQ-010 The block SHALL have port wdata, input, 2*WORD_LENGTH bits: write data.
REQ-011 The block SHALL have port busy, output, 1 bit, registered: a request is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, registered: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit, registered: one-cycle error pulse, coincident with done.
REQ-014 The block SHALL have port rdata, output, 2*WORD_LENGTH bits, registered: read data.

Function
REQ-015 Accept rule: a request SHALL be accepted on a falling edge (E0) where reset=1, req=1 and busy=0; rw, wide, addr and wdata SHALL be captured at E0.
REQ-016 While busy=1, req and all request inputs SHALL be ignored; no request SHALL be queued.
REQ-017 The state machine SHALL have three states: IDLE, WAIT and SECOND.
REQ-018 IDLE->WAIT SHALL occur on accept; the counter SHALL load LATENCY-1 and busy SHALL be set to 1.
REQ-019 In WAIT, the counter SHALL decrement while it is nonzero; at the edge where it is 0 (E0+LATENCY), the first access SHALL occur.
REQ-020 First access, narrow: read SHALL set rdata = {0, mem[addr]}; write SHALL set mem[addr] = wdata[WORD_LENGTH-1:0]; state SHALL go to IDLE, with done=1 and busy=0 at E0+LATENCY.
REQ-021 First access, wide: read SHALL load rdata upper half = mem[addr]; write SHALL set mem[addr] = wdata upper half; state SHALL go to SECOND.
REQ-022 SECOND, at E0+LATENCY+1: read SHALL load rdata lower half = mem[addr+1]; write SHALL set mem[addr+1] = wdata lower half; state SHALL go to IDLE, with done=1 and busy=0.
REQ-023 A wide request with addr = all ones SHALL NOT wrap. At E0+LATENCY there SHALL be no array access and rdata SHALL be unchanged; done=1, err=1, busy=0, and state SHALL go to IDLE.
REQ-024 done and err SHALL be high for exactly one cycle and SHALL return to 0 on the next edge.
REQ-025 rdata SHALL hold its value until the next read completion; writes SHALL NOT alter rdata.
REQ-026 A new request SHALL be acceptable on the edge after done; the minimum spacing between accepts SHALL be LATENCY+1 edges for narrow accesses and LATENCY+2 edges for wide accesses.
REQ-027 Reads SHALL return array contents as they stood before the same edge; there are no concurrent writers.

Reset
REQ-028 On a falling edge with reset=0, every memory word SHALL be cleared to 0.
REQ-029 On the same reset edge: state SHALL be IDLE, counter 0, busy 0, done 0, err 0, rdata 0.
REQ-030 Reset SHALL take priority over any in-flight request; the pending access SHALL be dropped, and no done or err SHALL be issued for it.

Verification (LATENCY=2, WORD_LENGTH=16, ADDRESS_SPACE=12)
REQ-031 Narrow write addr 0x010, wdata 0x0000BEEF at E0 -> busy=1 at E0 and E0+1; done=1, busy=0 at E0+2. A narrow read of 0x010 then returns rdata=0x0000BEEF.
REQ-032 Wide write addr 0x020, wdata 0x12345678 -> done at E0+3, mem[0x020]=0x1234, mem[0x021]=0x5678. A wide read of 0x020 then returns 0x12345678; a narrow read of 0x021 returns 0x00005678.
REQ-033 Wide read at 0xFFF -> done=1, err=1 at E0+2; rdata holds its previous value; mem[0xFFF] and mem[0x000] are unchanged.
REQ-034 req held high with addr changing to 0x055 during busy -> only the original request completes; mem[0x055] is untouched. A request held through the edge after done is accepted then.
REQ-035 Wide write accepted, then reset=0 at E0+1 -> no done pulse; all outputs are 0; reads of the target addresses return 0.
REQ-036 LATENCY=1 narrow read at E0 -> done at E0+1; a back-to-back second request is accepted at E0+2.
